// File: rtl/audio_frame_packer.sv
// Packs 32-bit {L,R} FIFO words into byte packets for the UART:
// HDR0, HDR1, seq, 4*SAMPLES_PER_FRAME payload bytes MSB-first, then an 8-bit sum of seq+payload.
module audio_frame_packer #(
  parameter int         SAMPLES_PER_FRAME = 64,
  parameter logic [7:0] HDR0              = 8'hA5,
  parameter logic [7:0] HDR1              = 8'h5A
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int WCW = $clog2(SAMPLES_PER_FRAME + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(SAMPLES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_SEQ, ST_FETCH, ST_WAITQ, ST_DATA, ST_CSUM
  } state_t;

  state_t         state, state_nx;
  logic [7:0]     seq;
  logic [7:0]     csum;
  logic [31:0]    shreg;
  logic [1:0]     byte_idx;
  logic [WCW-1:0] word_cnt;

  // Byte stream handshake: a byte moves on a cycle where tx_valid && tx_ready.
  // tx_valid and tx_data are decoded from registered state only, so they hold
  // steady through stalls and never depend combinationally on tx_ready.
  always_comb begin
    state_nx   = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    fifo_rd_en = 1'b0;
    case (state)
      ST_IDLE:  if (enable && !fifo_empty) state_nx = ST_HDR0;
      ST_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = HDR0;
        if (tx_ready) state_nx = ST_HDR1;
      end
      ST_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = HDR1;
        if (tx_ready) state_nx = ST_SEQ;
      end
      ST_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seq;
        if (tx_ready) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nx   = ST_WAITQ;
        end
      end
      ST_WAITQ: state_nx = ST_DATA;
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = shreg[31:24];
        if (tx_ready && byte_idx == 2'd3)
          state_nx = (word_cnt == LAST_WORD) ? ST_CSUM : ST_FETCH;
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      seq       <= 8'h00;
      csum      <= 8'h00;
      shreg     <= 32'h0;
      byte_idx  <= 2'd0;
      word_cnt  <= '0;
      frame_cnt <= 16'h0;
    end else begin
      state <= state_nx;
      case (state)
        ST_SEQ: if (tx_ready) csum <= seq;
        ST_WAITQ: begin
          shreg    <= fifo_q;
          byte_idx <= 2'd0;
        end
        ST_DATA: begin
          if (tx_ready) begin
            csum     <= csum + shreg[31:24];
            shreg    <= {shreg[23:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) word_cnt <= word_cnt + 1'b1;
          end
        end
        ST_CSUM: begin
          if (tx_ready) begin
            seq       <= seq + 8'd1;
            frame_cnt <= frame_cnt + 16'd1;
            word_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_audio_frame_packer.sv
// Directed bench for audio_frame_packer with SAMPLES_PER_FRAME=2: FIFO model,
// byte collector, hold/pop monitors and per-frame byte comparison.
module tb_audio_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_q = 32'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  audio_frame_packer #(.SAMPLES_PER_FRAME(2)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_q(fifo_q), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, flush drops everything unread
  logic [31:0] mem [0:2047];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_q <= mem[rd_ptr % 2048];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // tx_ready driver: mode 0 always ready, mode 1 ready roughly one cycle in three
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
  end

  // Monitors sample on the falling edge, where signals equal their rising-edge values
  logic [7:0] rx_q[$];
  int         pop_cnt = 0;
  int         bad_pop = 0;
  int         hold_err = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) hold_pend = 1'b0;
    else begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (fifo_rd_en) pop_cnt++;
      if (fifo_rd_en && fifo_empty) bad_pop++;
      if (hold_pend && (!tx_valid || tx_data != hold_data)) hold_err++;
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 2048] = w;
    wr_ptr++;
  endtask

  task automatic wait_fc(input string tag, input logic [15:0] target, input int budget);
    int n = 0;
    while (frame_cnt != target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, frame_cnt, target);
  endtask

  task automatic wait_bytes(input string tag, input int count, input int budget);
    int n = 0;
    while (rx_q.size() < count && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, (rx_q.size() >= count), 1);
  endtask

  task automatic cmp_frame(input string tag, input int base, input logic [7:0] seq,
                           input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0] e [12];
    logic [7:0] cs;
    e[0] = 8'hA5;
    e[1] = 8'h5A;
    e[2] = seq;
    for (int i = 0; i < 4; i++) begin
      e[3+i] = w0[31-8*i -: 8];
      e[7+i] = w1[31-8*i -: 8];
    end
    cs = seq;
    for (int i = 3; i < 11; i++) cs = cs + e[i];
    e[11] = cs;
    if (rx_q.size() < base + 12) check({tag, "_len"}, rx_q.size(), base + 12);
    else for (int i = 0; i < 12; i++) check(tag, rx_q[base+i], e[i]);
  endtask

  localparam logic [31:0] W0 = 32'h11223344;
  localparam logic [31:0] W1 = 32'hAABBCCDD;

  initial begin
    logic [7:0] exp1 [12];
    int base;
    int pop0;
    exp1 = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8};

    // reset state
    tick(3);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(2);
    check("idle_empty_busy", busy, 0);

    // basic frame, hand-computed byte stream
    base = rx_q.size();
    pop0 = pop_cnt;
    push(W0);
    push(W1);
    wait_fc("f1_done", 16'd1, 200);
    tick(2);
    check("f1_len", rx_q.size(), base + 12);
    if (rx_q.size() >= base + 12)
      for (int i = 0; i < 12; i++) check("f1_byte", rx_q[base+i], exp1[i]);
    check("f1_pops", pop_cnt - pop0, 2);
    check("f1_busy", busy, 0);

    // backpressured frame, seq advances to 01
    ready_mode = 1;
    base = rx_q.size();
    pop0 = pop_cnt;
    push(W0);
    push(W1);
    wait_fc("f2_done", 16'd2, 2000);
    tick(2);
    ready_mode = 0;
    cmp_frame("f2", base, 8'h01, W0, W1);
    check("f2_pops", pop_cnt - pop0, 2);
    check("f2_hold", hold_err, 0);

    // FIFO underrun mid-frame
    base = rx_q.size();
    pop0 = pop_cnt;
    push(W0);
    tick(50);
    check("f3_pause_bytes", rx_q.size(), base + 7);
    check("f3_pause_pops", pop_cnt - pop0, 1);
    check("f3_pause_valid", tx_valid, 0);
    check("f3_pause_busy", busy, 1);
    push(W1);
    wait_fc("f3_done", 16'd3, 200);
    tick(2);
    cmp_frame("f3", base, 8'h02, W0, W1);
    check("f3_pops", pop_cnt - pop0, 2);

    // enable dropped during payload byte 2
    base = rx_q.size();
    pop0 = pop_cnt;
    push(W0);
    push(W1);
    wait_bytes("f5_start", base + 4, 200);
    enable = 1'b0;
    wait_fc("f5_done", 16'd4, 200);
    tick(2);
    cmp_frame("f5", base, 8'h03, W0, W1);
    push(32'h01020304);
    push(32'h05060708);
    tick(30);
    check("f5_idle_busy", busy, 0);
    check("f5_no_header", rx_q.size(), base + 12);
    check("f5_pops", pop_cnt - pop0, 2);

    // asynchronous reset mid-DATA
    base = rx_q.size();
    enable = 1'b1;
    wait_bytes("f6_start", base + 5, 200);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("f6_tx_valid", tx_valid, 0);
    check("f6_rd_en", fifo_rd_en, 0);
    check("f6_busy", busy, 0);
    check("f6_frame_cnt", frame_cnt, 0);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    rst_n = 1'b1;
    tick(2);

    // 257 back-to-back frames: seq wraps FE FF 00, first frame restarts at 00
    base = rx_q.size();
    pop0 = pop_cnt;
    for (int k = 0; k < 257; k++) begin
      push(W0 ^ k);
      push(W1 + k);
    end
    wait_fc("f4_done", 16'd257, 8000);
    tick(2);
    check("f4_pops", pop_cnt - pop0, 514);
    for (int k = 0; k < 257; k++)
      cmp_frame("f4", base + 12*k, k[7:0], W0 ^ k, W1 + k);

    check("pop_while_empty", bad_pop, 0);
    check("hold_total", hold_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
